// File: rtl/psum_out_stream_packer_if.sv
// Beat input and AXI-Stream output bundle of psum_out_stream_packer.
// master = packer side, slave = upstream serialiser / downstream DMA side.
interface psum_out_stream_packer_if #(
    parameter int TDATA_W = 32,
    parameter int IN_W    = 1,
    parameter int USER_W  = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [TDATA_W-1:0] m_axis_tdata;
    logic               m_axis_tlast;
    logic [USER_W-1:0]  m_axis_tuser;

    modport master (
        input  in_valid, in_data, m_axis_tready,
        output in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
    modport slave (
        output in_valid, in_data, m_axis_tready,
        input  in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/psum_out_stream_packer.sv
// Packs IN_WIDTH-bit psum beats into AXI-Stream words through a small output FIFO,
// with partial-word flush on layer_finish. Optional stall counter: PSUM_PACK_STALL_CNT_EN.
module psum_out_stream_packer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int IN_WIDTH             = 1,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              operation,
    input  logic                    layer_finish,
    psum_out_stream_packer_if.master bus,
    output logic                    layer_done
`ifdef PSUM_PACK_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);
    localparam int LANES   = C_M_AXIS_TDATA_WIDTH / IN_WIDTH;
    localparam int USER_W  = $clog2(LANES + 1);
    localparam int PTR_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + USER_W + C_M_AXIS_TDATA_WIDTH;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);
    localparam logic [AW:0]      DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_PACK, ST_FLUSH_WAIT} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic                            r_run;
    logic [PTR_W-1:0]                r_lane_ptr;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_asm;
    logic [ENTRY_W-1:0]              r_pend;
    logic [ENTRY_W-1:0]              r_fifo [FIFO_DEPTH];
    logic [AW-1:0]                   r_wr_ptr;
    logic [AW-1:0]                   r_rd_ptr;
    logic [AW:0]                     r_count;
    logic                            r_layer_done;

    logic                            w_accept;
    logic                            w_pop;
    logic                            w_space;
    logic                            w_push;
    logic                            w_hold_pend;
    logic                            w_done_nopush;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] w_asm_new;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] w_flush_data;
    logic [USER_W-1:0]               w_filled;
    logic [ENTRY_W-1:0]              w_flush_entry;
    logic [ENTRY_W-1:0]              w_push_entry;
    logic [ENTRY_W-1:0]              w_head;

    assign bus.in_ready = r_run && (r_state == ST_PACK) && (r_count < DEPTH_CNT);
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Assembly with the incoming beat merged in; a lane-0 write starts a fresh word.
    always_comb begin
        w_asm_new = (r_lane_ptr == '0) ? '0 : r_asm;
        for (int l = 0; l < LANES; l++) begin
            if (r_lane_ptr == PTR_W'(l)) begin
                w_asm_new[l*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end
        end
    end

    assign w_filled      = USER_W'(r_lane_ptr) + USER_W'(w_accept);
    assign w_flush_data  = w_accept ? w_asm_new : ((r_lane_ptr == '0) ? '0 : r_asm);
    assign w_flush_entry = {1'b1, w_filled, w_flush_data};

    assign w_head             = r_fifo[r_rd_ptr];
    assign bus.m_axis_tvalid  = (r_count != '0);
    assign {bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata} =
        bus.m_axis_tvalid ? w_head : '0;
    assign w_pop   = bus.m_axis_tvalid && bus.m_axis_tready;
    assign w_space = (r_count < DEPTH_CNT) || w_pop;

    always_comb begin
        w_state_next  = r_state;
        w_push        = 1'b0;
        w_push_entry  = r_pend;
        w_hold_pend   = 1'b0;
        w_done_nopush = 1'b0;
        case (r_state)
            ST_PACK: begin
                if (layer_finish) begin
                    if ((w_filled == '0) && (operation != 2'd0)) begin
                        w_done_nopush = 1'b1;
                    end else if (w_space) begin
                        w_push       = 1'b1;
                        w_push_entry = w_flush_entry;
                    end else begin
                        w_hold_pend  = 1'b1;
                        w_state_next = ST_FLUSH_WAIT;
                    end
                end else if (w_accept && (r_lane_ptr == LAST_LANE)) begin
                    w_push       = 1'b1;
                    w_push_entry = {1'b0, USER_W'(LANES), w_asm_new};
                end
            end
            ST_FLUSH_WAIT: begin
                if (w_space) begin
                    w_push       = 1'b1;
                    w_state_next = ST_PACK;
                end
            end
            default: w_state_next = ST_PACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PACK;
            r_run        <= 1'b0;
            r_lane_ptr   <= '0;
            r_asm        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            if ((r_state == ST_PACK) && layer_finish) begin
                r_lane_ptr <= '0;
            end else if (w_accept) begin
                r_lane_ptr <= (r_lane_ptr == LAST_LANE) ? '0 : r_lane_ptr + 1'b1;
            end
            if (w_accept) begin
                r_asm <= w_asm_new;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_layer_done <= (w_pop && w_head[ENTRY_W-1]) || w_done_nopush;
        end
    end

    // Payload storage carries no reset; validity is tracked by r_count and r_state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
        if (w_hold_pend) begin
            r_pend <= w_flush_entry;
        end
    end

    assign layer_done = r_layer_done;

`ifdef PSUM_PACK_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_layer_done) begin
            r_stall_cnt <= '0;
        end else if (bus.in_valid && !bus.in_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
